// File: rtl/prco_pkg.sv
// Shared PRCO core constants: datapath widths, fetch FSM encodings and PC helpers.
package prco_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  // Sequential successor; wraps to word 0 after the last valid memory word.
  function automatic logic [ADDR_W-1:0] pc_increment(
    input logic [ADDR_W-1:0] pc,
    input logic [ADDR_W-1:0] last
  );
    if (pc == last) begin
      return {ADDR_W{1'b0}};
    end else begin
      return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/prco_pc_next.sv
// PC successor selection at retire: branch target taken verbatim, otherwise wrapping increment.
module prco_pc_next
  import prco_pkg::*;
#(
  parameter logic [ADDR_W-1:0] P_LMEM_DEPTH = 16'd255
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] pc_next
);

  // Out-of-range branch targets pass through; only the increment path wraps.
  always_comb begin
    if (branch_en) begin
      pc_next = branch_addr;
    end else begin
      pc_next = pc_increment(pc, P_LMEM_DEPTH);
    end
  end

endmodule

// File: rtl/prco_fetch.sv
// PRCO fetch stage: owns the PC, issues single outstanding memory fetches and holds the word for decode.
module prco_fetch
  import prco_pkg::*;
#(
  parameter logic [ADDR_W-1:0] P_RESET_PC   = 16'h0000,
  parameter logic [ADDR_W-1:0] P_LMEM_DEPTH = 16'd255,
  parameter int unsigned       P_TIMEOUT    = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_halt,
  input  logic               i_ce_wb,
  input  logic               i_branch_en,
  input  logic [ADDR_W-1:0]  i_branch_addr,
  input  logic               i_ce_dec,
  input  logic [INSTR_W-1:0] i_mem_douta,
  output logic               q_ce_fetch,
  output logic [ADDR_W-1:0]  q_mem_addr,
  output logic [ADDR_W-1:0]  q_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_instr_valid,
  output logic               q_halted,
  output logic               q_fault
);

  localparam int unsigned    CNT_W        = $clog2(P_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(P_TIMEOUT - 1);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_retire;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture, timeout;

  prco_pc_next #(
    .P_LMEM_DEPTH (P_LMEM_DEPTH)
  ) u_pc_next (
    .pc          (pc),
    .branch_en   (i_branch_en),
    .branch_addr (i_branch_addr),
    .pc_next     (pc_retire)
  );

  // Next-state, PC update and wait-counter logic.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_run) begin
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_nxt   = {CNT_W{1'b0}};
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_ce_dec) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end else if (cnt == TIMEOUT_LAST) begin
          // No response in time: flag it and retry the same address.
          timeout   = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = S_ISSUE;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (i_ce_wb) begin
          pc_nxt = pc_retire;
          if (i_halt) begin
            state_nxt = S_HALT;
          end else if (!i_run) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ISSUE;
          end
        end else begin
          state_nxt = S_HOLD;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; fetch strobe is high exactly while in S_ISSUE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= S_IDLE;
      pc            <= P_RESET_PC;
      cnt           <= {CNT_W{1'b0}};
      q_ce_fetch    <= 1'b0;
      q_mem_addr    <= P_RESET_PC;
      q_pc          <= P_RESET_PC;
      q_instr       <= {INSTR_W{1'b0}};
      q_instr_valid <= 1'b0;
      q_halted      <= 1'b0;
      q_fault       <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      cnt           <= cnt_nxt;
      q_ce_fetch    <= (state_nxt == S_ISSUE);
      if (state_nxt == S_ISSUE) begin
        q_mem_addr <= pc_nxt;
      end
      if (capture) begin
        q_instr <= i_mem_douta;
        q_pc    <= pc;
      end
      q_instr_valid <= capture;
      q_halted      <= (state_nxt == S_HALT);
      if (timeout) begin
        q_fault <= 1'b1;
      end
    end
  end

endmodule
